cpu_mem_responder: RTL and testbench

Memory-side responder for the single-cycle-visible CPU memory ports: serves the instruction-fetch port and the data load/store port from two on-chip word arrays. Includes a boot loader that fills both arrays from a valid/ready word stream and holds the CPU in reset (`cpu_rst_n`) until loading completes. Sits between the CPU and the testbench/host, replacing ad-hoc memory models.

---
 rtl/cpu_mem_pkg.sv | 21 ++
 rtl/cpu_mem_responder_word_mem.sv | 28 ++
 rtl/cpu_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder.
// Contents: FSM state enum, word width, NOP fetch word, index-width helper.
package cpu_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RELEASE,
        S_RUN
    } state_t;

    // Index width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_word_mem.sv
// word_mem: DEPTH x 32-bit word array, asynchronous read, synchronous write.
// Ports: clk; wen/waddr/wdata write port; raddr/rdata combinational read port.
// Contents are not reset.
module word_mem
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: boot-loads imem then dmem from a valid/ready word stream,
// holds the CPU in reset until loading completes, then serves the CPU
// instruction port and data load/store port with zero-latency reads.
// Ports: clk, rst (async active-high); loader load_valid/load_ready/
// load_data/load_last/load_err; cpu_rst_n; inst_addr/instruction;
// data_addr/data_wen/data_write/data_read; oob_err.
// Optional feature: define CPU_MEM_BOUNDS_CHECK_EN to reject CPU addresses
// with bits set above the index width (read 0, store dropped, oob_err set).
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = 256,
    parameter int unsigned DMEM_DEPTH     = 256,
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_err,
    output logic              cpu_rst_n,
    input  logic [WORD_W-1:0] inst_addr,
    output logic [WORD_W-1:0] instruction,
    input  logic [WORD_W-1:0] data_addr,
    input  logic              data_wen,
    input  logic [WORD_W-1:0] data_write,
    output logic [WORD_W-1:0] data_read,
    output logic              oob_err
);

    localparam int unsigned IW        = idx_w(IMEM_DEPTH);
    localparam int unsigned DW        = idx_w(DMEM_DEPTH);
    localparam int unsigned MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
    localparam int unsigned PTR_W     = idx_w(MAX_DEPTH) + 1;
    localparam int unsigned CNT_W     = idx_w(RELEASE_CYCLES) + 1;

    localparam logic [PTR_W-1:0] IMEM_FULL = PTR_W'(IMEM_DEPTH);
    localparam logic [PTR_W-1:0] DMEM_FULL = PTR_W'(DMEM_DEPTH);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;

    logic              hs;
    logic              run;
    logic              seg_full;
    logic              i_oob;
    logic              d_oob;
    logic              imem_wen;
    logic              dmem_wen;
    logic [DW-1:0]     dmem_waddr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] imem_rdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic              unused_addr_bits;

    assign hs       = load_valid & load_ready;
    assign run      = (state == S_RUN);
    // ptr saturates at the segment depth; a handshake there is an overflow.
    assign seg_full = (state == S_LOAD_I) ? (ptr == IMEM_FULL) : (ptr == DMEM_FULL);

    // Loader and CPU store share the dmem write port; they never overlap in time.
    assign imem_wen   = (state == S_LOAD_I) & hs & ~seg_full;
    assign dmem_wen   = ((state == S_LOAD_D) & hs & ~seg_full) | (run & data_wen & ~d_oob);
    assign dmem_waddr = run ? data_addr[DW-1:0] : ptr[DW-1:0];
    assign dmem_wdata = run ? data_write : load_data;

    word_mem #(.DEPTH(IMEM_DEPTH)) u_imem (
        .clk   (clk),
        .wen   (imem_wen),
        .waddr (ptr[IW-1:0]),
        .wdata (load_data),
        .raddr (inst_addr[IW-1:0]),
        .rdata (imem_rdata)
    );

    word_mem #(.DEPTH(DMEM_DEPTH)) u_dmem (
        .clk   (clk),
        .wen   (dmem_wen),
        .waddr (dmem_waddr),
        .wdata (dmem_wdata),
        .raddr (data_addr[DW-1:0]),
        .rdata (dmem_rdata)
    );

    // CPU sees NOPs and zero data until the loader has released it.
    assign instruction = (run & ~i_oob) ? imem_rdata : NOP_WORD;
    assign data_read   = (run & ~d_oob) ? dmem_rdata : '0;

    // Upper address bits only matter when bounds checking is built in.
    assign unused_addr_bits = ^{inst_addr, data_addr};

    // Load sequencer: imem segment, dmem segment, reset-release delay, run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            load_ready <= 1'b0;
            cpu_rst_n  <= 1'b0;
            load_err   <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_LOAD_I;
                    load_ready <= 1'b1;
                end
                S_LOAD_I, S_LOAD_D: begin
                    if (hs) begin
                        if (seg_full) begin
                            load_err <= 1'b1;
                        end else begin
                            ptr <= ptr + PTR_W'(1);
                        end
                        if (load_last) begin
                            ptr <= '0;
                            if (state == S_LOAD_I) begin
                                state <= S_LOAD_D;
                            end else begin
                                state      <= S_RELEASE;
                                load_ready <= 1'b0;
                                cnt        <= '0;
                            end
                        end
                    end
                end
                S_RELEASE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == REL_LAST) begin
                        state     <= S_RUN;
                        cpu_rst_n <= 1'b1;
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state      <= S_IDLE;
                    load_ready <= 1'b0;
                    cpu_rst_n  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CPU_MEM_BOUNDS_CHECK_EN
    assign i_oob = (inst_addr >> IW) != 32'd0;
    assign d_oob = (data_addr >> DW) != 32'd0;

    // Sticky out-of-range flag, only meaningful once the CPU is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_err <= 1'b0;
        end else if (run && (i_oob || d_oob)) begin
            oob_err <= 1'b1;
        end
    end
`else
    assign i_oob   = 1'b0;
    assign d_oob   = 1'b0;
    assign oob_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed load/run/reset vectors,
// a segment-level reference model, a per-cycle compare process and a set of
// hand-computed literal expectations.
module tb_cpu_mem_responder;

    localparam int unsigned IMEM_D = 4;
    localparam int unsigned DMEM_D = 256;
    localparam int unsigned REL_C  = 2;
`ifdef CPU_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_err;
    logic        cpu_rst_n;
    logic [31:0] inst_addr = '0;
    logic [31:0] instruction;
    logic [31:0] data_addr = '0;
    logic        data_wen = 1'b0;
    logic [31:0] data_write = '0;
    logic [31:0] data_read;
    logic        oob_err;

    cpu_mem_responder #(
        .IMEM_DEPTH     (IMEM_D),
        .DMEM_DEPTH     (DMEM_D),
        .RELEASE_CYCLES (REL_C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_err    (load_err),
        .cpu_rst_n   (cpu_rst_n),
        .inst_addr   (inst_addr),
        .instruction (instruction),
        .data_addr   (data_addr),
        .data_wen    (data_wen),
        .data_write  (data_write),
        .data_read   (data_read),
        .oob_err     (oob_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase of the boot sequence plus memory images.
    typedef enum int {M_RESET, M_IMEM, M_DMEM, M_REL, M_RUN} mphase_t;
    mphase_t     ph = M_RESET;
    int unsigned seg_words = 0;
    int unsigned rel_left  = 0;
    bit          m_err = 1'b0;
    bit          m_oob = 1'b0;
    logic [31:0] imem_m [IMEM_D];
    logic [31:0] dmem_m [DMEM_D];
    bit          ik [IMEM_D];
    bit          dk [DMEM_D];

    task automatic model_step();
        int unsigned depth;
        int unsigned di;
        bit i_hi;
        bit d_hi;
        if (rst) begin
            ph = M_RESET; seg_words = 0; rel_left = 0; m_err = 1'b0; m_oob = 1'b0;
        end else begin
            case (ph)
                M_RESET: begin
                    ph = M_IMEM; seg_words = 0;
                end
                M_IMEM, M_DMEM: begin
                    if (load_valid) begin
                        depth = (ph == M_IMEM) ? IMEM_D : DMEM_D;
                        if (seg_words < depth) begin
                            if (ph == M_IMEM) begin
                                imem_m[seg_words] = load_data; ik[seg_words] = 1'b1;
                            end else begin
                                dmem_m[seg_words] = load_data; dk[seg_words] = 1'b1;
                            end
                        end else begin
                            m_err = 1'b1;
                        end
                        seg_words++;
                        if (load_last) begin
                            seg_words = 0;
                            if (ph == M_IMEM) ph = M_DMEM;
                            else begin ph = M_REL; rel_left = REL_C; end
                        end
                    end
                end
                M_REL: begin
                    rel_left--;
                    if (rel_left == 0) ph = M_RUN;
                end
                default: begin
                    i_hi = (inst_addr >= IMEM_D);
                    d_hi = (data_addr >= DMEM_D);
                    if (BOUNDS && (i_hi || d_hi)) m_oob = 1'b1;
                    if (data_wen && !(BOUNDS && d_hi)) begin
                        di = data_addr % DMEM_D;
                        dmem_m[di] = data_write; dk[di] = 1'b1;
                    end
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    int unsigned ci;
    int unsigned cd;
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("load_ready", 32'(load_ready), 32'(ph == M_IMEM || ph == M_DMEM));
            check("cpu_rst_n", 32'(cpu_rst_n), 32'(ph == M_RUN));
            check("load_err", 32'(load_err), 32'(m_err));
            check("oob_err", 32'(oob_err), 32'(m_oob));
            if (ph != M_RUN) begin
                check("instruction_not_run", instruction, 32'h0);
                check("data_read_not_run", data_read, 32'h0);
            end else begin
                ci = inst_addr % IMEM_D;
                cd = data_addr % DMEM_D;
                if (BOUNDS && inst_addr >= IMEM_D) check("instruction_oob", instruction, 32'h0);
                else if (ik[ci]) check("instruction", instruction, imem_m[ci]);
                if (BOUNDS && data_addr >= DMEM_D) check("data_read_oob", data_read, 32'h0);
                else if (dk[cd]) check("data_read", data_read, dmem_m[cd]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic last);
        load_valid = 1'b1; load_data = w; load_last = last;
        cyc();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 started = 1'b1;
        cyc(); cyc();
        inst_addr = 32'd1;
        #1;
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_oob_err", 32'(oob_err), 32'd0);
        check("rst_instruction", instruction, 32'h0);
        cyc();

        // First load: imem with gaps between handshakes, one dmem word.
        rst = 1'b0;
        cyc();
        check("ready_after_release", 32'(load_ready), 32'd1);
        send(32'h2001_0005, 1'b0);
        cyc(); cyc();
        send(32'h2002_0003, 1'b1);
        check("nop_while_loading", instruction, 32'h0);
        check("ready_in_dmem_seg", 32'(load_ready), 32'd1);
        send(32'h0000_00AA, 1'b1);
        check("release_edge0", 32'(cpu_rst_n), 32'd0);
        cyc();
        check("release_edge1", 32'(cpu_rst_n), 32'd0);
        cyc();
        check("release_edge2", 32'(cpu_rst_n), 32'd1);
        check("fetch_addr1", instruction, 32'h2002_0003);
        check("load_addr0", data_read, 32'h0000_00AA);

        // Store, then a second store to the same address: old value until the edge.
        data_addr = 32'd4; data_write = 32'h5555; data_wen = 1'b1;
        cyc();
        data_write = 32'h1234;
        #1;
        check("same_cycle_old", data_read, 32'h5555);
        cyc();
        data_wen = 1'b0;
        #1;
        check("store_visible", data_read, 32'h1234);

        // Loader inputs are ignored once running.
        load_valid = 1'b1; load_data = 32'hFFFF_FFFF; load_last = 1'b1;
        cyc();
        load_valid = 1'b0; load_last = 1'b0;
        check("run_ignores_loader", 32'(load_ready), 32'd0);
        check("run_stays_released", 32'(cpu_rst_n), 32'd1);

        // Address above the dmem index range.
        data_addr = 32'h100; data_write = 32'hBEEF; data_wen = 1'b1;
        #1;
        check("high_addr_read", data_read, BOUNDS ? 32'h0 : 32'h0000_00AA);
        cyc();
        data_wen = 1'b0; data_addr = 32'd0;
        #1;
        check("high_addr_store", data_read, BOUNDS ? 32'h0000_00AA : 32'h0000_BEEF);
        check("oob_sticky", 32'(oob_err), BOUNDS ? 32'd1 : 32'd0);
        cyc();

        // Reset from RUN, then overflow the imem segment.
        rst = 1'b1;
        #1;
        check("rst_run_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_run_oob_err", 32'(oob_err), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        for (int i = 1; i <= 6; i++) begin
            send(32'h1000_0000 + 32'(i), 1'b0);
            if (i == 4) check("no_err_at_depth", 32'(load_err), 32'd0);
            if (i == 5) check("err_on_overflow", 32'(load_err), 32'd1);
        end
        send(32'h1000_0007, 1'b1);
        check("overflow_last_to_dmem", 32'(load_ready), 32'd1);
        check("err_sticky", 32'(load_err), 32'd1);
        send(32'h0000_0077, 1'b0);

        // Reset during the dmem segment.
        rst = 1'b1;
        #1;
        check("rst_dmem_load_ready", 32'(load_ready), 32'd0);
        check("rst_dmem_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_dmem_load_err", 32'(load_err), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Reload: overwrites from index 0, retains untouched words.
        send(32'h0000_00A0, 1'b0);
        send(32'h0000_00A1, 1'b1);
        send(32'h0000_00D0, 1'b0);
        send(32'h0000_00D1, 1'b1);
        cyc(); cyc();
        check("reload_released", 32'(cpu_rst_n), 32'd1);
        inst_addr = 32'd0; data_addr = 32'd0;
        cyc();
        check("reload_imem0", instruction, 32'h0000_00A0);
        check("reload_dmem0", data_read, 32'h0000_00D0);
        inst_addr = 32'd2; data_addr = 32'd1;
        cyc();
        check("retained_imem2", instruction, 32'h1000_0003);
        check("reload_dmem1", data_read, 32'h0000_00D1);
        inst_addr = 32'd3; data_addr = 32'd4;
        cyc();
        check("retained_imem3", instruction, 32'h1000_0004);
        check("retained_dmem4", data_read, 32'h0000_1234);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
